// File: rtl/hs_mem_sdpram_rdstrm.sv
// Read-side streaming controller for hs_mem_sdpram: request stream in, 3-entry skid buffer, response stream out.
// Optional macro HS_MEM_RDSTRM_ADDR_ECHO_EN adds rsp_addr, echoing the address of each response.
module hs_mem_sdpram_rdstrm #(
  parameter type DATA_TYPE = logic [7:0],
  parameter int unsigned DATA_DEPTH = 16,
  localparam int unsigned ADDR_WIDTH = $clog2(DATA_DEPTH)
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [ADDR_WIDTH-1:0] req_addr,
  input  logic                  req_valid,
  output logic                  req_ready,
  output logic [ADDR_WIDTH-1:0] ram_raddr,
  output logic                  ram_ren,
  input  DATA_TYPE              ram_rdata,
  output DATA_TYPE              rsp_data,
  output logic                  rsp_valid,
  input  logic                  rsp_ready
`ifdef HS_MEM_RDSTRM_ADDR_ECHO_EN
  ,
  output logic [ADDR_WIDTH-1:0] rsp_addr
`endif
);

  logic       infl_q;
  logic [1:0] wptr_q;
  logic [1:0] rptr_q;
  logic [1:0] occ_q;
  logic       capture;
  logic       pop;
  DATA_TYPE   data_buf_q [3];

  function automatic logic [1:0] ptr_inc(input logic [1:0] p);
    return (p == 2'd2) ? 2'd0 : p + 2'd1;
  endfunction

  // Credits count both buffered entries and the read still in flight, so a
  // capture always has a free slot and req_ready never looks at rsp_ready.
  assign req_ready = !rst && ((3'(occ_q) + 3'(infl_q)) < 3'd3);
  assign ram_ren   = req_valid && req_ready;
  assign ram_raddr = req_addr;

  assign capture   = infl_q;
  assign rsp_valid = (occ_q != 2'd0);
  assign pop       = rsp_valid && rsp_ready;
  assign rsp_data  = data_buf_q[rptr_q];

  always_ff @(posedge clk) begin
    if (rst) begin
      infl_q <= 1'b0;
      wptr_q <= '0;
      rptr_q <= '0;
      occ_q  <= '0;
    end else begin
      infl_q <= ram_ren;
      if (capture) wptr_q <= ptr_inc(wptr_q);
      if (pop)     rptr_q <= ptr_inc(rptr_q);
      case ({capture, pop})
        2'b10:   occ_q <= occ_q + 2'd1;
        2'b01:   occ_q <= occ_q - 2'd1;
        default: occ_q <= occ_q;
      endcase
    end
  end

  // Storage is deliberately unreset; pointer reset alone invalidates it.
  always_ff @(posedge clk) begin
    if (capture) data_buf_q[wptr_q] <= ram_rdata;
  end

`ifdef HS_MEM_RDSTRM_ADDR_ECHO_EN
  logic [ADDR_WIDTH-1:0] addr_pipe_q;
  logic [ADDR_WIDTH-1:0] addr_buf_q [3];

  // Address delayed one stage so it lands in the buffer with its ram_rdata.
  always_ff @(posedge clk) begin
    if (ram_ren) addr_pipe_q <= ram_raddr;
    if (capture) addr_buf_q[wptr_q] <= addr_pipe_q;
  end

  assign rsp_addr = addr_buf_q[rptr_q];
`endif

  a_no_capture_when_full: assert property (
    @(posedge clk) disable iff (rst) !(occ_q == 2'd3 && infl_q)
  );

endmodule

// File: tb/tb_hs_mem_sdpram_rdstrm.sv
// Self-checking bench for hs_mem_sdpram_rdstrm: bench-side RAM, credit/queue reference model, directed scenarios.
module tb_hs_mem_sdpram_rdstrm;
  localparam int AW = 4;

  logic          clk = 1'b0;
  logic          rst;
  logic [AW-1:0] req_addr;
  logic          req_valid;
  logic          req_ready;
  logic [AW-1:0] ram_raddr;
  logic          ram_ren;
  logic [7:0]    ram_rdata;
  logic [7:0]    rsp_data;
  logic          rsp_valid;
  logic          rsp_ready;
`ifdef HS_MEM_RDSTRM_ADDR_ECHO_EN
  logic [AW-1:0] rsp_addr;
`endif

  hs_mem_sdpram_rdstrm #(.DATA_TYPE(logic [7:0]), .DATA_DEPTH(16)) dut (
    .clk(clk), .rst(rst),
    .req_addr(req_addr), .req_valid(req_valid), .req_ready(req_ready),
    .ram_raddr(ram_raddr), .ram_ren(ram_ren), .ram_rdata(ram_rdata),
    .rsp_data(rsp_data), .rsp_valid(rsp_valid), .rsp_ready(rsp_ready)
`ifdef HS_MEM_RDSTRM_ADDR_ECHO_EN
    , .rsp_addr(rsp_addr)
`endif
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_err = 0;
  int cyc = 0;
  bit chk_en = 0;

  function automatic void chk(string nm, logic [31:0] act, logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp, cyc);
    end
  endfunction

  // RAM with 1-cycle read latency; garbage on rdata whenever no read was issued.
  logic [7:0] mem [16];
  always @(posedge clk) begin
    if (ram_ren) ram_rdata <= mem[ram_raddr];
    else         ram_rdata <= 8'($urandom);
  end

  // Reference model: every accepted request is an outstanding credit; it becomes
  // visible two cycles after acceptance and leaves in order when consumed.
  typedef struct { logic [7:0] d; logic [AW-1:0] a; int rdy; } ent_t;
  ent_t mq[$];

  always @(posedge clk) begin
    bit acc, pp;
    acc = !rst && req_valid && (mq.size() < 3);
    pp  = !rst && (mq.size() > 0) && (mq[0].rdy <= cyc) && rsp_ready;
    if (rst) mq.delete();
    else begin
      if (pp)  void'(mq.pop_front());
      if (acc) mq.push_back('{d: mem[req_addr], a: req_addr, rdy: cyc + 2});
    end
    cyc++;
  end

  always @(negedge clk) begin
    logic er, ev;
    if (chk_en) begin
      er = !rst && (mq.size() < 3);
      chk("req_ready", req_ready, er);
      chk("ram_ren", ram_ren, req_valid && er);
      if (req_valid && er) chk("ram_raddr", ram_raddr, req_addr);
      ev = (mq.size() > 0) && (mq[0].rdy <= cyc);
      chk("rsp_valid", rsp_valid, ev);
      if (ev) begin
        chk("rsp_data", rsp_data, mq[0].d);
`ifdef HS_MEM_RDSTRM_ADDR_ECHO_EN
        chk("rsp_addr", rsp_addr, mq[0].a);
`endif
      end
    end
  end

  // Consumed responses, for literal sequence checks.
  typedef struct { logic [7:0] d; logic [AW-1:0] a; int c; } got_t;
  got_t got[$];
  always @(negedge clk) begin
    if (chk_en && !rst && rsp_valid && rsp_ready) begin
`ifdef HS_MEM_RDSTRM_ADDR_ECHO_EN
      got.push_back('{d: rsp_data, a: rsp_addr, c: cyc});
`else
      got.push_back('{d: rsp_data, a: '0, c: cyc});
`endif
    end
  end

  task automatic step();
    @(posedge clk); #1;
  endtask

  task automatic wait_got(int n, string nm);
    for (int k = 0; k < 100 && got.size() < n; k++) @(posedge clk);
    #1;
    chk(nm, got.size(), n);
  endtask

  task automatic issue(logic [AW-1:0] a);
    bit acc;
    acc = 0;
    req_valid = 1'b1;
    req_addr  = a;
    for (int k = 0; k < 50 && !acc; k++) begin
      @(negedge clk);
      acc = req_ready;
      step();
    end
    req_valid = 1'b0;
    if (!acc) chk("issue_timeout", 0, 1);
  endtask

  task automatic preload_linear();
    for (int i = 0; i < 16; i++) mem[i] = 8'(i + 8'h10);
  endtask

  initial begin
    logic [AW-1:0] bp_addr [4];
    int first, idx, acc_cnt, n_acc;

    rst = 1'b1; req_valid = 1'b1; req_addr = '0; rsp_ready = 1'b0;
    preload_linear();
    @(posedge clk); #1;
    chk_en = 1;

    // Reset held with a request pending
    repeat (3) begin
      @(negedge clk);
      chk("rst_ren", ram_ren, 0);
      chk("rst_req_ready", req_ready, 0);
      chk("rst_rsp_valid", rsp_valid, 0);
      step();
    end
    rst = 1'b0; req_valid = 1'b0;
    @(negedge clk);
    chk("post_rst_req_ready", req_ready, 1);
    step();

    // Back-to-back streaming
    got.delete(); rsp_ready = 1'b1; first = -1;
    for (int i = 0; i < 16; i++) begin
      req_valid = 1'b1; req_addr = AW'(i);
      @(negedge clk);
      chk("stream_accept", req_ready, 1);
      if (i == 0) first = cyc;
      step();
    end
    req_valid = 1'b0;
    wait_got(16, "stream_count");
    for (int i = 0; i < 16 && i < got.size(); i++) begin
      chk("stream_data", got[i].d, 32'(8'h10 + i));
      chk("stream_cycle", got[i].c, first + 2 + i);
    end

    // Backpressure: only three credits
    got.delete(); rsp_ready = 1'b0;
    bp_addr = '{4'd3, 4'd4, 4'd5, 4'd6};
    idx = 0; acc_cnt = 0;
    for (int k = 0; k < 8; k++) begin
      req_valid = 1'b1; req_addr = bp_addr[idx];
      @(negedge clk);
      if (req_ready) begin
        acc_cnt++;
        if (idx < 3) idx++;
      end
      step();
    end
    @(negedge clk);
    chk("bp_accepted", acc_cnt, 3);
    chk("bp_req_ready", req_ready, 0);
    chk("bp_rsp_valid", rsp_valid, 1);
    chk("bp_rsp_held", rsp_data, 8'h13);
    step();
    rsp_ready = 1'b1;
    issue(4'd6);
    wait_got(4, "bp_count");
    for (int i = 0; i < 4 && i < got.size(); i++) begin
      chk("bp_data", got[i].d, 32'(8'h13 + i));
`ifdef HS_MEM_RDSTRM_ADDR_ECHO_EN
      chk("bp_addr", got[i].a, 32'(3 + i));
`endif
    end

    // Random valid/ready for 1000 accepted requests
    for (int i = 0; i < 16; i++) mem[i] = 8'($urandom);
    got.delete(); n_acc = 0;
    for (int k = 0; k < 10000 && n_acc < 1000; k++) begin
      req_valid = 1'($urandom_range(0, 1));
      req_addr  = AW'($urandom);
      rsp_ready = 1'($urandom_range(0, 1));
      @(negedge clk);
      if (req_valid && req_ready) n_acc++;
      step();
    end
    req_valid = 1'b0; rsp_ready = 1'b1;
    chk("rand_accepted", n_acc, 1000);
    wait_got(1000, "rand_count");
    @(negedge clk);
    chk("rand_drained", rsp_valid, 0);
    step();

    // Reset with two buffered and one in flight
    preload_linear();
    got.delete(); rsp_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      req_valid = 1'b1; req_addr = AW'(i + 8);
      step();
    end
    req_valid = 1'b0; rst = 1'b1;
    step();
    rst = 1'b0;
    @(negedge clk);
    chk("midrst_rsp_valid", rsp_valid, 0);
    chk("midrst_req_ready", req_ready, 1);
    step();
    rsp_ready = 1'b1;
    issue(4'd7);
    wait_got(1, "midrst_count");
    if (got.size() > 0) chk("midrst_data", got[0].d, 8'h17);
    repeat (4) step();
    chk("midrst_no_stale", got.size(), 1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

endmodule

// File: doc/hs_mem_sdpram_rdstrm.md
# hs_mem_sdpram_rdstrm

Read-side streaming controller for `hs_mem_sdpram`: drives the RAM read port (`raddr`/`ren`/`rdata`, latency 1) and converts it into a valid/ready request stream (addresses in) and a valid/ready response stream (data out). Holds returning read data in a 3-entry skid FIFO so full throughput is sustained with no combinational path from `rsp_ready` to `req_ready`. Sits between any address generator (DMA, FIFO reader, table walker) and one `hs_mem_sdpram` instance; the write port stays with the producer.

## Interface
- `DATA_TYPE`, `logic[7:0]`: item type; must match the attached RAM.
- `DATA_DEPTH`, `16`: RAM depth; must match the attached RAM.
- `ADDR_WIDTH`, `$clog2(DATA_DEPTH)`: derived local parameter; not overridable.

- `clk`  in  1  single clock, rising edge.
- `rst`  in  1  reset, synchronous, active-high.
- `req_addr`  in  ADDR_WIDTH  read address.
- `req_valid`  in  1  request valid.
- `req_ready`  out  1  request accepted when `req_valid && req_ready`.
- `ram_raddr`  out  ADDR_WIDTH  to RAM `raddr`.
- `ram_ren`  out  1  to RAM `ren`.
- `ram_rdata`  in  DATA_TYPE  from RAM `rdata`.
- `rsp_data`  out  DATA_TYPE  read data, valid only with `rsp_valid`.
- `rsp_valid`  out  1  response valid.
- `rsp_ready`  in  1  response consumed when `rsp_valid && rsp_ready`.
- `rsp_addr`  out  ADDR_WIDTH  address of `rsp_data`; present only with `HS_MEM_RDSTRM_ADDR_ECHO_EN`.

## Operation
- State: `infl_q` (1 bit, read issued last cycle), 3-entry buffer with `wptr`/`rptr` (0..2, wrap 2→0), `occ_q` (0..3, 2 bits).
- `req_ready = !rst && (occ_q + infl_q < 3)`; depends on registers and `rst` only.
- Accept: `ram_ren = req_valid && req_ready`, `ram_raddr = req_addr` (combinational pass-through); `infl_q <= ram_ren`.
- Capture: when `infl_q`, `ram_rdata` written to buffer[`wptr`], `wptr` advances. `ram_rdata` ignored when `infl_q == 0`.
- Output: `rsp_valid = (occ_q != 0)`; `rsp_data = buffer[rptr]`; pop on `rsp_valid && rsp_ready`, `rptr` advances.
- `occ_q` next = `occ_q + capture - pop`; simultaneous capture and pop leaves `occ_q` unchanged, both pointers advance.
- Ordering strictly in request order; no reordering, no drops outside reset.
- Credit rule guarantees capture never finds buffer full (occ 3 with infl 1 is unreachable); implementation carries an assertion on it.
- Buffer storage not reset; only pointers, `occ_q`, `infl_q` reset.
- Reset mid-operation: buffer contents and any in-flight read discarded; `ram_rdata` in the cycle after `rst` deasserts is ignored (`infl_q` = 0).

## Timing
- Reset values: `req_ready` 0 while `rst` high, 1 in first cycle after; `rsp_valid` 0; `ram_ren` 0; `rsp_data`/`rsp_addr` don't-care.
- Latency: request accepted cycle N → `ram_ren` cycle N → `ram_rdata` valid cycle N+1 → captured at end of N+1 → `rsp_valid` cycle N+2.
- Throughput: one request per cycle sustained while `rsp_ready` held high (steady state occ 1, infl 1).
- `rsp_ready` low: at most 3 responses buffered; `req_ready` drops once `occ_q + infl_q` = 3, rises the cycle after a pop frees a credit.
- `rsp_valid`/`rsp_data` stable while `rsp_valid && !rsp_ready`.

## Configuration
- `HS_MEM_RDSTRM_ADDR_ECHO_EN` defined: `rsp_addr` port exists; buffer stores address alongside data (address pipelined one stage to align with `ram_rdata`); `rsp_addr` follows the same ordering/hold rules as `rsp_data`.
- Undefined: no `rsp_addr` port, no address storage; all other behaviour identical.

## Test plan
- Reset: hold `rst` 3 cycles with `req_valid` 1 → `ram_ren` 0, `req_ready` 0, `rsp_valid` 0; cycle after release `req_ready` 1.
- Streaming: RAM preloaded `mem[i] = i+0x10`, addresses 0..15 back-to-back, `rsp_ready` 1 → `ram_ren` high 16 consecutive cycles, responses 0x10..0x1F on 16 consecutive cycles starting 2 cycles after first accept.
- Backpressure: `rsp_ready` 0, issue addresses 3,4,5,6 → exactly 3 accepted, `req_ready` 0 thereafter, `rsp_data` held at `mem[3]`; raise `rsp_ready` → 3,4,5 then 6 delivered in order, no loss.
- Pointer wrap/simultaneous: random `req_valid`/`rsp_ready` (50%) for 1000 requests → output sequence equals request sequence, `occ_q` never exceeds 3, `ram_rdata` never captured with `infl_q` 0.
- Reset mid-flight: 2 responses buffered plus 1 in flight, pulse `rst` 1 cycle → `rsp_valid` 0 next cycle, stale RAM data never appears on `rsp_data`; new request after reset returns correct data.
- With `HS_MEM_RDSTRM_ADDR_ECHO_EN`: rerun backpressure scenario → `rsp_addr` 3,4,5,6 aligned with corresponding `rsp_data`.
